// File: rtl/halt_ctrl.sv
// CPU-side initiator of the simulation halt protocol: detects ebreak at commit,
// drains the pipeline, then hands a halt request (code + PC) to the harness.
module halt_ctrl #(
    parameter int          XLEN         = 64,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] EBREAK_INST  = 32'h00100073
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] a0_value,
    input  logic            halt_ack,
    output logic            stall_fetch,
    output logic            halt_valid,
    output logic [31:0]     halt_code,
    output logic [XLEN-1:0] halt_pc,
    output logic            halted,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam bit         NO_DRAIN   = (DRAIN_CYCLES == 0);

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            stall_r;
    logic            halt_valid_r;
    logic [31:0]     halt_code_r;
    logic [XLEN-1:0] halt_pc_r;
    logic            halted_r;
    logic [63:0]     instret_r;
    logic            detect_s;

    assign detect_s = commit_valid && (commit_inst == EBREAK_INST);

    // Halt sequencer: retire counting in RUN, capture on ebreak, drain, handshake, stop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_RUN;
            cnt_r        <= 4'd0;
            stall_r      <= 1'b0;
            halt_valid_r <= 1'b0;
            halt_code_r  <= 32'd0;
            halt_pc_r    <= '0;
            halted_r     <= 1'b0;
            instret_r    <= 64'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (commit_valid) begin
                        instret_r <= instret_r + 64'd1;
                    end
                    if (detect_s) begin
                        halt_code_r <= a0_value[31:0];
                        halt_pc_r   <= commit_pc;
                        stall_r     <= 1'b1;
                        if (NO_DRAIN) begin
                            halt_valid_r <= 1'b1;
                            state_r      <= ST_REPORT;
                        end else begin
                            cnt_r   <= DRAIN_INIT;
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                // Commits arriving here are in-flight leftovers and are not counted.
                ST_DRAIN: begin
                    if (cnt_r == 4'd1) begin
                        cnt_r        <= 4'd0;
                        halt_valid_r <= 1'b1;
                        state_r      <= ST_REPORT;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_REPORT: begin
                    if (halt_valid_r && halt_ack) begin
                        halt_valid_r <= 1'b0;
                        halted_r     <= 1'b1;
                        state_r      <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    stall_r  <= 1'b1;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_RUN;
                    cnt_r        <= 4'd0;
                    halt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_fetch = stall_r;
    assign halt_valid  = halt_valid_r;
    assign halt_code   = halt_code_r;
    assign halt_pc     = halt_pc_r;
    assign halted      = halted_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_halt_ctrl.sv
// Scoreboard bench for halt_ctrl: two instances (drain 3 and drain 0) share stimulus,
// an event-time reference model predicts every cycle's outputs.
module tb_halt_ctrl;

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] ADDI   = 32'h00000013;

    typedef struct {
        logic        stall;
        logic        hv;
        logic [31:0] code;
        logic [63:0] pc;
        logic        halted;
        logic [63:0] instret;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_inst = 32'd0;
    logic [63:0] commit_pc = 64'd0;
    logic [63:0] a0_value = 64'd0;
    logic        halt_ack = 1'b0;

    logic        stall3, hv3, halted3, stall0, hv0, halted0;
    logic [31:0] code3, code0;
    logic [63:0] pc3, pc0, instret3, instret0;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one slot per instance (0: drain 3, 1: drain 0)
    int          drain[2] = '{3, 0};
    longint      e_t[2];
    longint      a_t[2];
    logic [63:0] n_com[2];
    logic [31:0] m_code[2];
    logic [63:0] m_pc[2];
    longint      t;

    halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(3), .EBREAK_INST(EBREAK)) u_d3 (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .commit_pc(commit_pc), .a0_value(a0_value), .halt_ack(halt_ack),
        .stall_fetch(stall3), .halt_valid(hv3), .halt_code(code3), .halt_pc(pc3),
        .halted(halted3), .instret(instret3)
    );

    halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(0), .EBREAK_INST(EBREAK)) u_d0 (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .commit_pc(commit_pc), .a0_value(a0_value), .halt_ack(halt_ack),
        .stall_fetch(stall0), .halt_valid(hv0), .halt_code(code0), .halt_pc(pc0),
        .halted(halted0), .instret(instret0)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            e_t[d]    = -1;
            a_t[d]    = -1;
            n_com[d]  = 64'd0;
            m_code[d] = 32'd0;
            m_pc[d]   = 64'd0;
        end
        t = 0;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_stall3"}, {63'd0, stall3}, 64'd0);
        chk({tag, "_hv3"}, {63'd0, hv3}, 64'd0);
        chk({tag, "_code3"}, {32'd0, code3}, 64'd0);
        chk({tag, "_pc3"}, pc3, 64'd0);
        chk({tag, "_halted3"}, {63'd0, halted3}, 64'd0);
        chk({tag, "_instret3"}, instret3, 64'd0);
        chk({tag, "_stall0"}, {63'd0, stall0}, 64'd0);
        chk({tag, "_hv0"}, {63'd0, hv0}, 64'd0);
        chk({tag, "_halted0"}, {63'd0, halted0}, 64'd0);
        chk({tag, "_instret0"}, instret0, 64'd0);
    endtask

    // Called at a negedge: asserts reset, checks outputs clear at once, releases at a later negedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        commit_valid = 1'b0;
        halt_ack = 1'b0;
        #1;
        zero_check({tag, "_imm"});
        @(negedge clock);
        zero_check({tag, "_hold"});
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle of inputs (starting at a negedge), push predicted post-edge outputs.
    task automatic cyc(input logic cv, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] a0, input logic ack);
        exp_t e;
        commit_valid = cv;
        commit_inst  = inst;
        commit_pc    = pc;
        a0_value     = a0;
        halt_ack     = ack;
        for (int d = 0; d < 2; d++) begin
            if (e_t[d] < 0) begin
                if (cv) n_com[d] = n_com[d] + 64'd1;
                if (cv && inst == EBREAK) begin
                    e_t[d]    = t;
                    m_code[d] = a0[31:0];
                    m_pc[d]   = pc;
                end
            end else if (a_t[d] < 0 && t >= e_t[d] + 1 + drain[d] && ack) begin
                a_t[d] = t;
            end
            e.stall   = (e_t[d] >= 0);
            e.hv      = (e_t[d] >= 0) && (t + 1 >= e_t[d] + 1 + drain[d]) && (a_t[d] < 0);
            e.halted  = (a_t[d] >= 0);
            e.code    = m_code[d];
            e.pc      = m_pc[d];
            e.instret = n_com[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        t++;
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 64'd0, 64'd0, ack);
    endtask

    // Monitor: pops the prediction for the edge just taken and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d3_stall", {63'd0, stall3}, {63'd0, e.stall});
                chk("d3_halt_valid", {63'd0, hv3}, {63'd0, e.hv});
                chk("d3_halt_code", {32'd0, code3}, {32'd0, e.code});
                chk("d3_halt_pc", pc3, e.pc);
                chk("d3_halted", {63'd0, halted3}, {63'd0, e.halted});
                chk("d3_instret", instret3, e.instret);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d0_stall", {63'd0, stall0}, {63'd0, e.stall});
                chk("d0_halt_valid", {63'd0, hv0}, {63'd0, e.hv});
                chk("d0_halt_code", {32'd0, code0}, {32'd0, e.code});
                chk("d0_halt_pc", pc0, e.pc);
                chk("d0_halted", {63'd0, halted0}, {63'd0, e.halted});
                chk("d0_instret", instret0, e.instret);
            end
        end
    end

    initial begin
        model_clear();
        @(negedge clock);

        // 5 addi then ebreak a0=0, ack held high from the ebreak on
        do_reset("t1rst");
        for (int i = 0; i < 5; i++) cyc(1'b1, ADDI, 64'h1000 + 64'(i * 4), 64'd0, 1'b0);
        cyc(1'b1, EBREAK, 64'h1014, 64'd0, 1'b1);
        idle(8, 1'b1);
        chk("t1_instret", instret3, 64'd6);
        chk("t1_halted", {63'd0, halted3}, 64'd1);
        chk("t1_stall", {63'd0, stall3}, 64'd1);
        chk("t1_code", {32'd0, code3}, 64'd0);

        // Delayed ack: request held stable for many cycles
        do_reset("t2rst");
        cyc(1'b1, ADDI, 64'h8000_0000C, 64'd5, 1'b0);
        cyc(1'b1, EBREAK, 64'h8000_0010, 64'hFFFF_FFFF_0000_0001, 1'b0);
        idle(9, 1'b0);
        chk("t2_hv_wait", {63'd0, hv3}, 64'd1);
        chk("t2_code_wait", {32'd0, code3}, 64'd1);
        chk("t2_pc_wait", pc3, 64'h8000_0010);
        idle(4, 1'b0);
        idle(2, 1'b1);
        chk("t2_halted", {63'd0, halted3}, 64'd1);
        chk("t2_pc_final", pc3, 64'h8000_0010);

        // Commits and a second ebreak during drain are ignored
        do_reset("t3rst");
        cyc(1'b1, EBREAK, 64'h200, 64'h0000_0000_1234_5678, 1'b0);
        cyc(1'b1, ADDI, 64'h204, 64'd9, 1'b0);
        cyc(1'b1, EBREAK, 64'h208, 64'd7, 1'b0);
        idle(3, 1'b1);
        chk("t3_instret", instret3, 64'd1);
        chk("t3_code", {32'd0, code3}, 64'h1234_5678);
        chk("t3_pc", pc3, 64'h200);

        // Reset in REPORT aborts; a fresh ebreak reports the new code
        do_reset("t5rst");
        cyc(1'b1, EBREAK, 64'h300, 64'd11, 1'b0);
        idle(5, 1'b0);
        chk("t5_in_report", {63'd0, hv3}, 64'd1);
        do_reset("t5abort");
        cyc(1'b1, EBREAK, 64'h400, 64'd3, 1'b0);
        idle(6, 1'b1);
        chk("t5_code", {32'd0, code3}, 64'd3);
        chk("t5_halted", {63'd0, halted3}, 64'd1);

        // Ack in RUN has no effect
        do_reset("t6rst");
        idle(2, 1'b1);
        cyc(1'b1, ADDI, 64'h10, 64'd0, 1'b1);
        cyc(1'b1, ADDI, 64'h14, 64'd0, 1'b1);
        idle(3, 1'b1);
        chk("t6_instret", instret3, 64'd2);
        chk("t6_not_halted", {63'd0, halted3 | hv3 | stall3}, 64'd0);

        // Randomized episodes
        for (int ep = 0; ep < 10; ep++) begin
            do_reset("rnd_rst");
            for (int i = 0; i < 40; i++) begin
                logic        cv;
                logic [31:0] inst;
                cv   = 1'($urandom_range(0, 1));
                inst = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom();
                cyc(cv, inst, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    ($urandom_range(0, 3) == 0));
            end
        end

        idle(2, 1'b0);
        chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
